// File: rtl/dsi_pkg.sv
// Shared types, constants and the header ECC function for the DSI packet assembler.
package dsi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StCrcTail
  } dsi_state_e;

  localparam logic [5:0]  DT_DCS_SHORT_WR0 = 6'h05;
  localparam logic [5:0]  DT_DCS_LONG_WR   = 6'h39;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;

  // MIPI DSI 6-bit Hamming ECC over the 24 header bits.
  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^
           d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^
           d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^
           d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^
           d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^
           d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
           d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Combinational CRC-16 (reflected 0x8408) step over up to four bytes, LSB first.
module dsi_crc16
  import dsi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  byte_en,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        for (int i = 0; i < 8; i++) begin
          c = (c[0] ^ data[8*b+i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/dsi_packet_assembler.sv
// Builds DSI short/long packets (header, payload pass-through, CRC tail) for a lanes controller.
module dsi_packet_assembler
  import dsi_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [1:0]  pkt_vc,
  input  logic [5:0]  pkt_data_type,
  input  logic [15:0] pkt_word_count,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  input  logic        iface_data_rqst,
  output logic        busy,
  output logic        data_underflow
);

  dsi_state_e  state_q, state_d;
  logic        long_q;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [15:0] remain_q;
  logic [15:0] crc_q;
  logic        tail_two_q;

  logic [15:0] crc_nx;
  logic        final_word;
  logic [2:0]  k;
  logic [3:0]  byte_mask;
  logic [3:0]  crc_en;
  logic [31:0] pld_masked;
  logic        pld_xfer;
  logic [23:0] hdr24;

  assign final_word = (remain_q <= 16'd4);
  assign k          = final_word ? remain_q[2:0] : 3'd4;
  assign pld_xfer   = (state_q == StPayload) && pld_valid && iface_data_rqst;
  assign hdr24      = {wc_q, vc_q, dt_q};
  assign crc_en     = (state_q == StPayload) ? byte_mask : 4'h0;

  always_comb begin
    case (k)
      3'd1:    byte_mask = 4'h1;
      3'd2:    byte_mask = 4'h3;
      3'd3:    byte_mask = 4'h7;
      default: byte_mask = 4'hF;
    endcase
  end

  // Bytes past the payload length in the last word are zeroed, never forwarded.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      pld_masked[8*b +: 8] = byte_mask[b] ? pld_data[8*b +: 8] : 8'h00;
    end
  end

  dsi_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data    (pld_masked),
    .byte_en (crc_en),
    .crc_out (crc_nx)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (pkt_valid) state_d = StHeader;
      end
      StHeader: begin
        if (iface_data_rqst) begin
          if (!long_q)            state_d = StIdle;
          else if (wc_q == 16'd0) state_d = StCrcTail;
          else                    state_d = StPayload;
        end
      end
      StPayload: begin
        if (pld_xfer && final_word) begin
          state_d = (k <= 3'd2) ? StIdle : StCrcTail;
        end
      end
      StCrcTail: begin
        if (iface_data_rqst) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt_ready        = 1'b0;
    pld_ready        = 1'b0;
    iface_write_data = 32'h0;
    iface_write_strb = 4'h0;
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    data_underflow   = 1'b0;
    busy             = (state_q != StIdle);
    case (state_q)
      StIdle: pkt_ready = 1'b1;
      StHeader: begin
        iface_write_rqst = 1'b1;
        iface_write_strb = 4'hF;
        iface_write_data = {2'b00, dsi_ecc(hdr24), hdr24};
        iface_last_word  = !long_q;
      end
      StPayload: begin
        pld_ready        = iface_data_rqst;
        iface_write_rqst = pld_valid;
        iface_write_data = pld_data;
        data_underflow   = iface_data_rqst && !pld_valid;
        if (pld_valid) begin
          iface_write_strb = 4'hF;
          if (final_word) begin
            case (k)
              3'd1: begin
                iface_write_data = {8'h00, crc_nx, pld_masked[7:0]};
                iface_write_strb = 4'h7;
                iface_last_word  = 1'b1;
              end
              3'd2: begin
                iface_write_data = {crc_nx, pld_masked[15:0]};
                iface_last_word  = 1'b1;
              end
              3'd3:    iface_write_data = {crc_nx[7:0], pld_masked[23:0]};
              default: iface_write_data = pld_masked;
            endcase
          end
        end
      end
      StCrcTail: begin
        iface_write_rqst = 1'b1;
        iface_last_word  = 1'b1;
        if (tail_two_q) begin
          iface_write_data = {16'h0, crc_q};
          iface_write_strb = 4'h3;
        end else begin
          iface_write_data = {24'h0, crc_q[15:8]};
          iface_write_strb = 4'h1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      long_q     <= 1'b0;
      vc_q       <= 2'b0;
      dt_q       <= 6'b0;
      wc_q       <= 16'h0;
      remain_q   <= 16'h0;
      crc_q      <= CRC_INIT;
      tail_two_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pkt_valid) begin
            long_q <= pkt_long;
            vc_q   <= pkt_vc;
            dt_q   <= pkt_data_type;
            wc_q   <= pkt_word_count;
          end
        end
        StHeader: begin
          crc_q <= CRC_INIT;
          if (iface_data_rqst) begin
            remain_q   <= long_q ? wc_q : 16'h0;
            tail_two_q <= 1'b1;
          end
        end
        StPayload: begin
          if (pld_xfer) begin
            remain_q   <= remain_q - {13'b0, k};
            crc_q      <= crc_nx;
            tail_two_q <= (k == 3'd4);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Self-checking bench: packets are rebuilt as byte streams from the DSI framing rules and compared.
module tb_dsi_packet_assembler;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        pkt_valid, pkt_ready, pkt_long;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_data_type;
  logic [15:0] pkt_word_count;
  logic [31:0] pld_data;
  logic        pld_valid, pld_ready;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst, iface_last_word, iface_data_rqst;
  logic        busy, data_underflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] rx_data[$];
  logic [3:0]  rx_strb[$];
  logic        rx_last[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_strb[$];
  logic        exp_last[$];
  int          uf_seen;
  logic [7:0]  pay [0:255];

  dsi_packet_assembler dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (pkt_ready),
    .pkt_long         (pkt_long),
    .pkt_vc           (pkt_vc),
    .pkt_data_type    (pkt_data_type),
    .pkt_word_count   (pkt_word_count),
    .pld_data         (pld_data),
    .pld_valid        (pld_valid),
    .pld_ready        (pld_ready),
    .iface_write_data (iface_write_data),
    .iface_write_strb (iface_write_strb),
    .iface_write_rqst (iface_write_rqst),
    .iface_last_word  (iface_last_word),
    .iface_data_rqst  (iface_data_rqst),
    .busy             (busy),
    .data_underflow   (data_underflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Inputs change 1ns after the rising edge, so the falling edge sees what the next edge will take.
  always @(negedge clk_sys) begin
    if (iface_write_rqst && iface_data_rqst) begin
      rx_data.push_back(iface_write_data);
      rx_strb.push_back(iface_write_strb);
      rx_last.push_back(iface_last_word);
    end
    if (data_underflow) uf_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] ref_ecc(input logic [23:0] h);
    logic [23:0] m [6];
    logic [5:0]  e;
    m = '{24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    for (int p = 0; p < 6; p++) e[p] = ^(h & m[p]);
    return e;
  endfunction

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ pay[i][b]) c = (c >> 1) ^ 16'h8408;
        else                  c = c >> 1;
      end
    end
    return c;
  endfunction

  // Header word, then payload bytes + CRC (low, high) packed four to a word.
  task automatic build_expected(input logic lng, input logic [1:0] vc, input logic [5:0] dt,
                                input logic [15:0] wc);
    logic [23:0] h;
    logic [7:0]  st[$];
    logic [15:0] c;
    logic [31:0] d;
    logic [3:0]  s;
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    h = {wc, vc, dt};
    exp_data.push_back({2'b00, ref_ecc(h), h});
    exp_strb.push_back(4'hF);
    exp_last.push_back(!lng);
    if (lng) begin
      for (int i = 0; i < int'(wc); i++) st.push_back(pay[i]);
      c = ref_crc(int'(wc));
      st.push_back(c[7:0]);
      st.push_back(c[15:8]);
      for (int w = 0; w < st.size(); w += 4) begin
        d = 32'h0;
        s = 4'h0;
        for (int j = 0; j < 4; j++) begin
          if (w + j < st.size()) begin
            d[8*j +: 8] = st[w+j];
            s[j] = 1'b1;
          end
        end
        exp_data.push_back(d);
        exp_strb.push_back(s);
        exp_last.push_back(w + 4 >= st.size());
      end
    end
  endtask

  task automatic run_packet(input logic lng, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input int stall_pct, input int gap_pct,
                            input string tag);
    int   idx, exp_uf, cyc, guard;
    logic drq, pv, in_pay;
    build_expected(lng, vc, dt, wc);
    rx_data.delete(); rx_strb.delete(); rx_last.delete();
    uf_seen = 0;
    idx = 0;
    exp_uf = 0;
    @(posedge clk_sys); #1;
    pkt_long = lng; pkt_vc = vc; pkt_data_type = dt; pkt_word_count = wc;
    pkt_valid = 1'b1;
    iface_data_rqst = 1'b0;
    pld_valid = 1'b0;
    guard = 0;
    while (!pkt_ready && guard < 20) begin
      @(posedge clk_sys); #1;
      guard++;
    end
    total++;
    if (pkt_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s pkt_ready: got %b want 1", tag, pkt_ready);
      pkt_valid = 1'b0;
      return;
    end
    @(posedge clk_sys); #1;
    pkt_valid = 1'b0;
    cyc = 0;
    while (rx_data.size() < exp_data.size() && cyc < 3000) begin
      in_pay = (rx_data.size() >= 1) && lng && (idx < int'(wc));
      drq = (int'($urandom_range(99)) >= stall_pct);
      pv  = in_pay ? (int'($urandom_range(99)) >= gap_pct) : 1'b0;
      for (int j = 0; j < 4; j++) begin
        pld_data[8*j +: 8] = (idx + j < int'(wc)) ? pay[idx+j] : 8'($urandom);
      end
      if (in_pay && drq && !pv) exp_uf++;
      iface_data_rqst = drq;
      pld_valid = pv;
      @(posedge clk_sys); #1;
      if (in_pay && drq && pv) idx += 4;
      cyc++;
    end
    iface_data_rqst = 1'b0;
    pld_valid = 1'b0;
    total++;
    if (rx_data.size() != exp_data.size()) begin
      bad++;
      $display("FAIL %s word_count: got %0d want %0d", tag, rx_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < rx_data.size(); i++) begin
      total++;
      if (rx_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %h want %h", tag, i, rx_data[i], exp_data[i]);
      end
      total++;
      if (rx_strb[i] !== exp_strb[i]) begin
        bad++;
        $display("FAIL %s strb[%0d]: got %h want %h", tag, i, rx_strb[i], exp_strb[i]);
      end
      total++;
      if (rx_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL %s last[%0d]: got %b want %b", tag, i, rx_last[i], exp_last[i]);
      end
    end
    total++;
    if (uf_seen != exp_uf) begin
      bad++;
      $display("FAIL %s underflow: got %0d want %0d", tag, uf_seen, exp_uf);
    end
    iface_data_rqst = 1'b1;
    repeat (2) begin
      @(posedge clk_sys); #1;
    end
    iface_data_rqst = 1'b0;
    total++;
    if (rx_data.size() != exp_data.size() || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after: got words=%0d busy=%b want words=%0d busy=0", tag,
               rx_data.size(), busy, exp_data.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    total++;
    if (iface_write_rqst !== 1'b0 || iface_last_word !== 1'b0 || iface_write_strb !== 4'h0 ||
        data_underflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rqst=%b last=%b strb=%h uf=%b busy=%b want all 0",
               iface_write_rqst, iface_last_word, iface_write_strb, data_underflow, busy);
    end
    @(posedge clk_sys); #1;
    rst = 1'b0;
    @(negedge clk_sys);
    total++;
    if (pkt_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", pkt_ready, busy);
    end
  endtask

  task automatic test_short();
    run_packet(1'b0, 2'd0, 6'h05, 16'h0029, 0, 0, "short");
    total++;
    if (rx_data.size() < 1 || rx_data[0] !== 32'h1C002905 || rx_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL short_const: got %h want 1c002905 with last", (rx_data.size() > 0) ?
               rx_data[0] : 32'hx);
    end
  endtask

  task automatic test_long_n9();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    run_packet(1'b1, 2'd0, 6'h39, 16'd9, 0, 0, "long9");
    total++;
    if (rx_data.size() < 4 || rx_data[1] !== 32'h34333231 || rx_data[2] !== 32'h38373635 ||
        rx_data[3] !== 32'h006F9139 || rx_strb[3] !== 4'h7 || rx_last[3] !== 1'b1) begin
      bad++;
      $display("FAIL long9_const: got %0d words last=%h want last=006f9139 strb 7",
               rx_data.size(), (rx_data.size() > 3) ? rx_data[3] : 32'hx);
    end
  endtask

  task automatic test_long_n0();
    run_packet(1'b1, 2'd1, 6'h39, 16'd0, 0, 0, "long0");
    total++;
    if (rx_data.size() != 2 || rx_data[1] !== 32'h0000FFFF || rx_strb[1] !== 4'h3) begin
      bad++;
      $display("FAIL long0_const: got %0d words tail=%h want 2 words tail=0000ffff strb 3",
               rx_data.size(), (rx_data.size() > 1) ? rx_data[1] : 32'hx);
    end
  endtask

  task automatic test_n3_n4();
    for (int n = 3; n <= 4; n++) begin
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      run_packet(1'b1, 2'd2, 6'h39, 16'(n), 0, 0, (n == 3) ? "n3" : "n4");
      total++;
      if (rx_data.size() != 3 || rx_strb[1] !== 4'hF || rx_last[1] !== 1'b0 ||
          rx_strb[2] !== ((n == 3) ? 4'h1 : 4'h3) || rx_last[2] !== 1'b1) begin
        bad++;
        $display("FAIL n%0d_tail: got %0d words want 3 with tail strb %0d", n, rx_data.size(),
                 (n == 3) ? 1 : 3);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] n;
    logic        lng;
    for (int p = 0; p < 24; p++) begin
      lng = ($urandom_range(3) != 0);
      n = 16'($urandom_range(40));
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_packet(lng, 2'($urandom), 6'($urandom), n, 35, 35, "random");
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    @(posedge clk_sys); #1;
    pkt_long = 1'b1; pkt_vc = 2'd3; pkt_data_type = 6'h39; pkt_word_count = 16'd20;
    pkt_valid = 1'b1;
    @(posedge clk_sys); #1;
    pkt_valid = 1'b0;
    iface_data_rqst = 1'b1;
    pld_valid = 1'b1;
    pld_data = {pay[3], pay[2], pay[1], pay[0]};
    repeat (2) begin
      @(posedge clk_sys); #1;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (iface_write_rqst !== 1'b0 || iface_last_word !== 1'b0 || iface_write_strb !== 4'h0 ||
        data_underflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got rqst=%b last=%b strb=%h uf=%b busy=%b want all 0",
               iface_write_rqst, iface_last_word, iface_write_strb, data_underflow, busy);
    end
    pld_valid = 1'b0;
    iface_data_rqst = 1'b0;
    @(posedge clk_sys); #1;
    rst = 1'b0;
    rx_data.delete(); rx_strb.delete(); rx_last.delete();
    iface_data_rqst = 1'b1;
    repeat (3) begin
      @(posedge clk_sys); #1;
    end
    iface_data_rqst = 1'b0;
    total++;
    if (rx_data.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_residue: got words=%0d busy=%b want 0 0", rx_data.size(), busy);
    end
    for (int i = 0; i < 13; i++) pay[i] = 8'($urandom);
    run_packet(1'b1, 2'd1, 6'h39, 16'd13, 20, 20, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid = 1'b0; pkt_long = 1'b0; pkt_vc = 2'd0; pkt_data_type = 6'h0;
    pkt_word_count = 16'h0; pld_data = 32'h0; pld_valid = 1'b0; iface_data_rqst = 1'b0;
    uf_seen = 0;
    test_reset();
    test_short();
    test_long_n9();
    test_long_n0();
    test_n3_n4();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsi_packet_assembler.md
DSI_PACKET_ASSEMBLER -- requirements
Module: dsi_packet_assembler

Interface
REQ-001 clk_sys  in  1  single system clock; all logic on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 pkt_valid / pkt_ready  in / out  1 / 1  packet-descriptor handshake; transfer when both high.
REQ-004 pkt_long  in  1  1 = long packet (header + payload + CRC); 0 = short packet (header only).
REQ-005 pkt_vc  in  2  virtual channel.
REQ-006 pkt_data_type  in  6  DSI data type.
REQ-007 pkt_word_count  in  16  long: payload byte count N; short: {data1, data0}.
REQ-008 pld_data  in  32  payload word, little-endian (byte0 in [7:0] is sent first).
REQ-009 pld_valid / pld_ready  in / out  1 / 1  payload handshake; transfer when both high.
REQ-010 iface_write_data  out  32  word to the lanes controller.
REQ-011 iface_write_strb  out  4  valid-byte mask, contiguous from bit 0.
REQ-012 iface_write_rqst  out  1  output word valid.
REQ-013 iface_last_word  out  1  current word is the final word of the packet.
REQ-014 iface_data_rqst  in  1  lanes controller ready; a word transfers when iface_write_rqst && iface_data_rqst.
REQ-015 busy  out  1  high whenever state != IDLE.
REQ-016 data_underflow  out  1  one-cycle pulse when payload is starved (REQ-026).

Function
REQ-017 States are IDLE, HEADER, PAYLOAD and CRC_TAIL.
- pkt_ready is high only in IDLE.
- A descriptor transfer registers all pkt_* fields and moves to HEADER.
REQ-018 HEADER drives iface_write_rqst=1, strb=4'hF and data={ECC, WC[15:8], WC[7:0], {VC, DT}}.
- ECC = {2'b00, dsi_ecc(bits[23:0])}, the MIPI DSI Hamming code.
- The header appears the cycle after the descriptor transfer.
REQ-019 HEADER exit on transfer:
- short packet: last_word=1, return to IDLE;
- long packet with N=0: go to CRC_TAIL;
- otherwise go to PAYLOAD.
REQ-020 PAYLOAD is a combinational pass-through:
- pld_ready = iface_data_rqst;
- iface_write_rqst = pld_valid;
- iface_write_data = pld_data, merged per REQ-022.
REQ-021 A 16-bit byte counter holds the remaining payload bytes.
- It decrements by min(4, remaining) on each payload transfer.
- The final payload word has k = remaining bytes, 1..4.
- Payload bytes beyond N in the final word are ignored.
REQ-022 On the final payload word, CRC bytes (low byte first) fill the free byte lanes:
- k=1: strb 4'h7, last_word=1;
- k=2: strb 4'hF, last_word=1;
- k=3: strb 4'hF, CRC low byte only, then CRC_TAIL carries the high byte;
- k=4: strb 4'hF, then CRC_TAIL carries both CRC bytes.
REQ-023 CRC_TAIL drives the remaining CRC bytes in [7:0] / [15:0].
- strb is 4'h1 or 4'h3; last_word=1.
- Return to IDLE on transfer.
REQ-024 CRC definition: CRC-16, reflected polynomial 0x8408 (x^16+x^12+x^5+1).
- Init 0xFFFF, LSB-first, no final XOR.
- Re-initialised in HEADER.
- Updated only over valid payload bytes.
- N=0 yields CRC 0xFFFF.
REQ-025 Outputs hold stable while iface_write_rqst=1 and iface_data_rqst=0, except in PAYLOAD, where they track pld_*.
REQ-026 data_underflow pulses in any PAYLOAD cycle with iface_data_rqst=1 and pld_valid=0.
- State and counters hold in that cycle.
REQ-027 iface_write_rqst=0 in IDLE; strb and last_word are 0 whenever iface_write_rqst=0.

Reset
REQ-028 While rst is high:
- state=IDLE; CRC=0xFFFF; counters and registered fields are 0;
- iface_write_rqst, iface_last_word, iface_write_strb, data_underflow and busy are 0;
- pkt_ready=1 after rst is released.
REQ-029 rst asserted mid-packet aborts the packet immediately; no partial word is emitted after reset is released.

Structure
REQ-030 Package dsi_pkg holds:
- the state enum;
- data-type constants: DT_DCS_SHORT_WR0=6'h05, DT_DCS_LONG_WR=6'h39;
- CRC_INIT=16'hFFFF, CRC_POLY_REFL=16'h8408;
- function dsi_ecc.
REQ-031 Sub-module dsi_crc16 computes the combinational next-CRC over 0..4 bytes selected by a mask.
- The assembler instantiates it once and holds the CRC register.

Verification
REQ-032 Short packet, DT=0x05, VC=0, WC=16'h0029, iface_data_rqst=1 -> one word 32'h1C002905, strb F, last_word=1; state back to IDLE.
REQ-033 Long packet, DT=0x39, N=9, bytes 0x31..0x39 -> header, then 0x34333231, 0x38373635, 0x006F9139 with strb 7 and last_word=1 (CRC 0x6F91).
REQ-034 Long packet, N=0 -> header with WC=0, then 32'h0000FFFF, strb 3, last_word=1.
REQ-035 N=3 and N=4 -> final payload word strb F, then CRC_TAIL word strb 1 (N=3) or strb 3 (N=4); last_word is asserted only on the tail word.
REQ-036 Random stalls on iface_data_rqst and pld_valid gaps -> outputs held, byte stream matches the reference model, data_underflow counts equal the starved cycles.
REQ-037 rst pulsed during PAYLOAD -> all outputs 0 at once; next packet correct.
